// File: rtl/dbus_master.sv
// Data-bus initiator for the CPU load/store path: turns one byte/half/word request
// into a word-aligned d_* bus access and returns extended load data or a fault.
module dbus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_fault,
  output logic        d_access,
  output logic [31:0] d_addr,
  output logic [3:0]  d_bytesel,
  output logic [31:0] d_wr_val,
  output logic        d_wr_en,
  input  logic [31:0] d_data,
  input  logic        d_ack
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  bsel_q, bsel_d;
  logic [31:0] wval_q, wval_d;
  logic        wen_q, wen_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic        illegal;
  logic [3:0]  bsel_c;
  logic [31:0] wval_c;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  assign illegal = (req_size == 2'b11)
                 || (req_size == 2'b01 && req_addr[0])
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  always_comb begin
    case (req_size)
      2'b00:   begin bsel_c = 4'b0001 << req_addr[1:0];          wval_c = {4{req_wdata[7:0]}};  end
      2'b01:   begin bsel_c = 4'b0011 << {req_addr[1], 1'b0};    wval_c = {2{req_wdata[15:0]}}; end
      default: begin bsel_c = 4'b1111;                           wval_c = req_wdata;            end
    endcase
  end

  // Lane extraction uses the address captured at acceptance, not the live request.
  assign rd_byte = d_data[{lane_q, 3'b000} +: 8];
  assign rd_half = d_data[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'b00:   rd_ext = {{24{sgn_q & rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = {{16{sgn_q & rd_half[15]}}, rd_half};
      default: rd_ext = d_data;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    bsel_d  = bsel_q;
    wval_d  = wval_q;
    wen_d   = wen_q;
    wr_d    = wr_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    lane_d  = lane_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d   = req_wr;
          size_d = req_size;
          sgn_d  = req_signed;
          lane_d = req_addr[1:0];
          if (illegal) begin
            fault_d = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            addr_d  = {req_addr[31:2], 2'b00};
            bsel_d  = bsel_c;
            wval_d  = wval_c;
            wen_d   = req_wr;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (d_ack) begin
          fault_d = 1'b0;
          rdata_d = wr_q ? '0 : rd_ext;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          fault_d = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        wen_d   = 1'b0;
        fault_d = 1'b0;
        rdata_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: every register here is plain control/datapath state with a defined reset
  // value, and all updates are non-blocking so the block reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      bsel_q  <= '0;
      wval_q  <= '0;
      wen_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      lane_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      bsel_q  <= bsel_d;
      wval_q  <= wval_d;
      wen_q   <= wen_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rdata_q;
  assign rsp_fault = fault_q;
  assign d_access  = (state_q == S_ACCESS);
  assign d_addr    = addr_q;
  assign d_bytesel = bsel_q;
  assign d_wr_val  = wval_q;
  assign d_wr_en   = wen_q;

endmodule

// File: tb/tb_dbus_master.sv
// Scoreboard bench for dbus_master: directed requests push expected responses,
// a negedge monitor pops and compares them whenever rsp_valid is seen.
module tb_dbus_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        d_access;
  logic [31:0] d_addr;
  logic [3:0]  d_bytesel;
  logic [31:0] d_wr_val;
  logic        d_wr_en;
  logic [31:0] d_data = '0;
  logic        d_ack;

  logic        ack_q = 1'b0;
  logic        ack_en = 1'b1;
  logic        stray_ack = 1'b0;
  assign d_ack = ack_q | stray_ack;

  dbus_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .d_access(d_access), .d_addr(d_addr), .d_bytesel(d_bytesel),
    .d_wr_val(d_wr_val), .d_wr_en(d_wr_en), .d_data(d_data), .d_ack(d_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int access_cnt = 0;
  int rsp_cnt = 0;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          acc;
    int          lat;
    int          id;
  } exp_t;
  exp_t sb[$];
  int   next_id = 0;

  logic [31:0] mem [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: acks one cycle after the strobe, applies stores lane by lane.
  always @(posedge clk) begin
    ack_q <= 1'b0;
    if (d_access && ack_en) begin
      logic [31:0] w;
      w = mem.exists(int'(d_addr[31:2])) ? mem[int'(d_addr[31:2])] : 32'h0;
      ack_q  <= 1'b1;
      d_data <= w;
      if (d_wr_en) begin
        for (int i = 0; i < 4; i++)
          if (d_bytesel[i]) w[8*i +: 8] = d_wr_val[8*i +: 8];
        mem[int'(d_addr[31:2])] = w;
      end
    end
  end

  always @(negedge clk) begin
    if (d_access) access_cnt++;
    if (rst_n && rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("rsp%0d_data", e.id), rsp_data, e.data);
        check($sformatf("rsp%0d_fault", e.id), {31'd0, rsp_fault}, {31'd0, e.fault});
        check($sformatf("rsp%0d_latency", e.id), cyc - e.acc, e.lat);
      end
    end
  end

  task automatic push_exp(input logic [31:0] data, input logic fault, input int acc, input int lat);
    exp_t e;
    e.data = data; e.fault = fault; e.acc = acc; e.lat = lat; e.id = next_id;
    next_id++;
    sb.push_back(e);
  endtask

  task automatic drive(input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_wr = wr; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
  endtask

  task automatic xact(input logic wr, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_fault, input int exp_lat,
                      input int exp_acc, input logic [3:0] exp_bsel, input logic [31:0] exp_wval);
    int acc0;
    logic done, stable;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    @(negedge clk);
    drive(wr, size, sgn, addr, wdata);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    push_exp(exp_data, exp_fault, cyc, exp_lat);
    acc0 = access_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);
    check("d_wr_en_c1", {31'd0, d_wr_en}, (exp_acc != 0) ? {31'd0, wr} : 32'd0);
    if (exp_acc != 0) begin
      check("d_access_c1", {31'd0, d_access}, 32'd1);
      check("d_addr_c1", d_addr, exp_addr);
      check("d_bytesel_c1", {28'd0, d_bytesel}, {28'd0, exp_bsel});
      check("d_wr_val_c1", d_wr_val, exp_wval);
    end
    done = rsp_valid;
    stable = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (exp_acc != 0 && d_addr !== exp_addr) stable = 1'b0;
      done = rsp_valid;
    end
    check("rsp_seen", {31'd0, done}, 32'd1);
    if (exp_acc != 0) check("d_addr_stable", {31'd0, stable}, 32'd1);
    @(posedge clk);
    check("access_count", access_cnt - acc0, exp_acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_d_access", {31'd0, d_access}, 32'd0);
    check("rst_d_addr", d_addr, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    xact(1'b1, 2'b10, 1'b0, 32'h100, 32'hdeadbeef, 32'h0,        1'b0, 3, 1, 4'b1111, 32'hdeadbeef);
    xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0,        32'hdeadbeef, 1'b0, 3, 1, 4'b1111, 32'h0);
    xact(1'b1, 2'b00, 1'b0, 32'h203, 32'h11223380, 32'h0,        1'b0, 3, 1, 4'b1000, 32'h80808080);
    xact(1'b0, 2'b00, 1'b1, 32'h203, 32'h0,        32'hffffff80, 1'b0, 3, 1, 4'b1000, 32'h0);
    xact(1'b0, 2'b00, 1'b0, 32'h203, 32'h0,        32'h00000080, 1'b0, 3, 1, 4'b1000, 32'h0);
    xact(1'b1, 2'b01, 1'b0, 32'h302, 32'h00008001, 32'h0,        1'b0, 3, 1, 4'b1100, 32'h80018001);
    xact(1'b0, 2'b01, 1'b1, 32'h302, 32'h0,        32'hffff8001, 1'b0, 3, 1, 4'b1100, 32'h0);
    xact(1'b0, 2'b01, 1'b0, 32'h302, 32'h0,        32'h00008001, 1'b0, 3, 1, 4'b1100, 32'h0);
    xact(1'b0, 2'b10, 1'b1, 32'h300, 32'h0,        32'h80010000, 1'b0, 3, 1, 4'b1111, 32'h0);

    xact(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1, 0, 4'b0000, 32'h0);
    xact(1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0, 4'b0000, 32'h0);
    xact(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 4'b0000, 32'h0);

    ack_en = 1'b0;
    xact(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 10, 1, 4'b1111, 32'h0);
    ack_en = 1'b1;
    xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hdeadbeef, 1'b0, 3, 1, 4'b1111, 32'h0);

    // Stray acknowledge while idle.
    r0 = rsp_cnt;
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_ack_no_rsp", rsp_cnt - r0, 0);
    check("stray_ack_ready", {31'd0, req_ready}, 32'd1);

    // Reset while waiting on an unanswered load.
    ack_en = 1'b0;
    r0 = rsp_cnt;
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 32'h500, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("wait_d_addr", d_addr, 32'h500);
    rst_n = 1'b0;
    #1;
    check("midrst_d_addr", d_addr, 32'h0);
    check("midrst_d_bytesel", {28'd0, d_bytesel}, 32'h0);
    check("midrst_d_wr_val", d_wr_val, 32'h0);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (15) @(negedge clk);
    check("midrst_no_rsp", rsp_cnt - r0, 0);
    xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hdeadbeef, 1'b0, 3, 1, 4'b1111, 32'h0);

    // Back-to-back: req_valid held high across two word loads.
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    n = cyc;
    push_exp(32'hdeadbeef, 1'b0, n, 3);
    push_exp(32'hdeadbeef, 1'b0, n + 4, 3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_c%0d", k), {31'd0, req_ready}, (k == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_ready_c5", {31'd0, req_ready}, 32'd0);
    repeat (5) @(negedge clk);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_master.md
Name: dbus_master

Overview:
- Data-bus initiator for the CPU load/store path. Drives the d_* bus that the data-side RAM and peripherals respond to.
- Accepts one load or store request at a time from the pipeline: byte, half or word, signed or unsigned.
- Places the request on the bus as word-aligned address, byte-lane selects and lane-replicated write data, then waits for d_ack.
- Returns aligned, extended load data, or a fault for misaligned or unanswered accesses.

Parameters:
- TIMEOUT_CYCLES, 255, WAIT-state cycles without d_ack before a bus fault is reported; legal range 1..65535.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  sign-extend load result; ignored for stores and word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  32  load result; 0 for stores and faults.
- rsp_fault  out  1  qualifies rsp_valid; 1 = misaligned/reserved size or bus timeout.
- d_access  out  1  one-cycle bus strobe.
- d_addr  out  32  {req_addr[31:2], 2'b00}.
- d_bytesel  out  4  active byte lanes.
- d_wr_val  out  32  lane-replicated store data.
- d_wr_en  out  1  store qualifier.
- d_data  in  32  read data, valid when d_ack=1.
- d_ack  in  1  responder completion.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE, timeout counter 0.
  - rsp_valid, rsp_fault, d_access and d_wr_en are 0; rsp_data, d_addr, d_bytesel and d_wr_val are 0.
  - req_ready is 1 combinationally from IDLE, but no request is accepted while rst_n is low.
  - Reset mid-transaction abandons it; no rsp_valid is produced.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: req_ready=1. On req_valid at a clock edge, capture the request.
  - If the request is illegal, go to RESP with fault=1 and perform no bus access. Illegal means size 11, half with addr[0]=1, or word with addr[1:0]!=0.
  - Otherwise load d_addr, d_bytesel, d_wr_val and d_wr_en, and go to ACCESS.
- Lane and data encoding:
  - bytesel: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0] (addr[1] picks 0011 or 1100); word 4'b1111.
  - d_wr_val: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- ACCESS: exactly one cycle with d_access=1, then WAIT with counter cleared.
  - d_ack sampled in ACCESS is ignored.
- WAIT: d_access=0, counter increments every cycle.
  - On d_ack=1: for loads, capture the extracted lane from d_data. Byte uses d_data[8*addr[1:0]+:8]; half uses d_data[16*addr[1]+:16]. Zero- or sign-extend per req_signed. Go to RESP with fault=0.
  - Else if counter == TIMEOUT_CYCLES-1: go to RESP with fault=1.
  - A d_ack arriving on the same edge that the timeout is reached wins: no fault.
- Bus-output stability:
  - d_addr, d_bytesel, d_wr_val and d_wr_en hold stable from ACCESS until RESP exits.
  - d_wr_en is 0 outside ACCESS/WAIT/RESP of a store.
- RESP: rsp_valid=1 for exactly one cycle with rsp_data/rsp_fault, then IDLE.
  - rsp_data is 0 for stores and faults.
  - rsp_valid returns to 0 the following cycle.
- Latency and throughput:
  - With a responder that acks one cycle after d_access: request accepted at edge 0, d_access during cycle 1, d_ack during cycle 2, rsp_valid during cycle 3.
  - Peak throughput is 1 request per 4 cycles.
  - Faulting misaligned requests complete with rsp_valid during cycle 1.
- d_ack in IDLE or RESP is ignored: no state change, no response.

Test Plan:
- Word store 0xdeadbeef @0x100, then word load @0x100 -> exactly one d_access cycle each, d_bytesel=1111; load rsp_data=0xdeadbeef, rsp_fault=0; rsp_valid 3 cycles after acceptance.
- Byte store 0x80 @0x203, signed byte load @0x203 -> d_addr=0x200, d_bytesel=1000, d_wr_val=0x80808080; rsp_data=0xffffff80. Unsigned load -> 0x00000080.
- Half store 0x8001 @0x302, signed/unsigned half load -> d_bytesel=1100, d_wr_val=0x80018001; rsp_data 0xffff8001 / 0x00008001.
- Half @0x101, word @0x102, size 11 -> no d_access; rsp_valid next cycle with rsp_fault=1, rsp_data=0.
- Load to an address that never acks, TIMEOUT_CYCLES=8 -> rsp_fault=1 after 8 WAIT cycles; d_addr held stable throughout; next request accepted.
- rst_n low during WAIT -> outputs reset immediately, no rsp_valid. Stray d_ack in IDLE -> no response. Back-to-back req_valid -> req_ready low until RESP exits.
